max30003_spi_responder: RTL

Synthesizable SPI-slave model of the MAX30003 ECG front end. It is the responder end of the 32-bit register-access protocol the ECG driver issues. It is used for FPGA-in-loop and simulation bring-up without silicon. It holds the configuration register file, executes SW_RST/SYNCH commands, and serves ECG_FIFO reads from an internal sample FIFO that is fed by a test pattern source.

---
 rtl/max30003_spi_responder.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/max30003_spi_responder.sv
// SPI-slave model of the MAX30003 ECG front end: config registers,
// SW_RST/SYNCH commands and an ECG sample FIFO fed by a pattern source.
// Ports: clk/rst (async active-high), sclk/mosi/cs/miso (SPI mode 0),
//   sample_data/sample_valid (FIFO push), cnfg_gen/cnfg_ecg (registers),
//   fifo_level/fifo_overflow (FIFO status), sw_rst_pulse/synch_pulse.
module max30003_spi_responder #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [23:0] INFO_VAL   = 24'h500000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sclk,
  input  logic                            mosi,
  input  logic                            cs,
  output logic                            miso,
  input  logic [23:0]                     sample_data,
  input  logic                            sample_valid,
  output logic [23:0]                     cnfg_gen,
  output logic [23:0]                     cnfg_ecg,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            fifo_overflow,
  output logic                            sw_rst_pulse,
  output logic                            synch_pulse
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [6:0] A_SW_RST = 7'h08;
  localparam logic [6:0] A_SYNCH  = 7'h09;
  localparam logic [6:0] A_INFO   = 7'h0F;
  localparam logic [6:0] A_GEN    = 7'h10;
  localparam logic [6:0] A_CAL    = 7'h12;
  localparam logic [6:0] A_EMUX   = 7'h14;
  localparam logic [6:0] A_ECG    = 7'h15;
  localparam logic [6:0] A_RTOR1  = 7'h1D;
  localparam logic [6:0] A_FIFO   = 7'h21;

  localparam logic [23:0] GEN_DEF   = 24'h080004;
  localparam logic [23:0] CAL_DEF   = 24'h700000;
  localparam logic [23:0] EMUX_DEF  = 24'h300000;
  localparam logic [23:0] ECG_DEF   = 24'h805000;
  localparam logic [23:0] RTOR1_DEF = 24'h3FA300;
  localparam logic [23:0] EMPTY_WD  = 24'h000030;

  // cs synchronizer resets low so a frame already in progress at reset
  // release is not mistaken for a fresh one; armed_q waits for cs high.
  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic mosi_s1_q, mosi_s2_q;
  logic cs_s1_q, cs_s2_q;

  logic        armed_q, armed_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [22:0] shift_q, shift_d;
  logic [6:0]  addr_q, addr_d;
  logic        rd_q, rd_d;
  logic        pop_ok_q, pop_ok_d;
  logic [23:0] rd_sh_q, rd_sh_d;
  logic        miso_q, miso_d;
  logic [23:0] gen_q, gen_d;
  logic [23:0] cal_q, cal_d;
  logic [23:0] emux_q, emux_d;
  logic [23:0] ecg_q, ecg_d;
  logic [23:0] rtor_q, rtor_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic        ovf_q, ovf_d;
  logic        sw_q, sw_d;
  logic        sy_q, sy_d;
  logic [23:0] mem_q [FIFO_DEPTH];

  logic        rise, fall, frame_en;
  logic [7:0]  cmd_byte;
  logic [23:0] wdata;
  logic [23:0] rd_word;
  logic        pop, flush, full, push_ok;

  assign rise     = sclk_s2_q & ~sclk_s3_q;
  assign fall     = ~sclk_s2_q & sclk_s3_q;
  assign frame_en = armed_q & ~cs_s2_q;
  assign cmd_byte = {shift_q[6:0], mosi_s2_q};
  assign wdata    = {shift_q[22:0], mosi_s2_q};
  assign full     = (level_q == LW'(FIFO_DEPTH));

  always_comb begin
    case (cmd_byte[7:1])
      A_INFO:  rd_word = INFO_VAL;
      A_GEN:   rd_word = gen_q;
      A_CAL:   rd_word = cal_q;
      A_EMUX:  rd_word = emux_q;
      A_ECG:   rd_word = ecg_q;
      A_RTOR1: rd_word = rtor_q;
      A_FIFO:  rd_word = (level_q != '0) ? mem_q[rd_ptr_q] : EMPTY_WD;
      default: rd_word = 24'h0;
    endcase
  end

  always_comb begin
    armed_d  = armed_q | cs_s2_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    addr_d   = addr_q;
    rd_d     = rd_q;
    pop_ok_d = pop_ok_q;
    rd_sh_d  = rd_sh_q;
    miso_d   = miso_q;
    gen_d    = gen_q;
    cal_d    = cal_q;
    emux_d   = emux_q;
    ecg_d    = ecg_q;
    rtor_d   = rtor_q;
    sw_d     = 1'b0;
    sy_d     = 1'b0;
    pop      = 1'b0;
    flush    = 1'b0;
    if (!frame_en) begin
      cnt_d    = '0;
      shift_d  = '0;
      rd_d     = 1'b0;
      pop_ok_d = 1'b0;
      rd_sh_d  = '0;
      miso_d   = 1'b0;
    end else if (rise) begin
      shift_d = {shift_q[21:0], mosi_s2_q};
      if (cnt_q != 6'd32) cnt_d = cnt_q + 6'd1;
      if (cnt_q == 6'd7) begin
        addr_d = cmd_byte[7:1];
        if (cmd_byte[0]) begin
          rd_d     = 1'b1;
          rd_sh_d  = rd_word;
          miso_d   = rd_word[23];
          pop_ok_d = (cmd_byte[7:1] == A_FIFO) && (level_q != '0);
        end
      end
      if (cnt_q == 6'd31) begin
        miso_d = 1'b0;
        if (rd_q) begin
          pop = pop_ok_q && (level_q != '0);
        end else begin
          case (addr_q)
            A_SW_RST: begin
              gen_d  = GEN_DEF;
              cal_d  = CAL_DEF;
              emux_d = EMUX_DEF;
              ecg_d  = ECG_DEF;
              rtor_d = RTOR1_DEF;
              flush  = 1'b1;
              sw_d   = 1'b1;
            end
            A_SYNCH: begin
              flush = 1'b1;
              sy_d  = 1'b1;
            end
            A_GEN:   gen_d  = wdata;
            A_CAL:   cal_d  = wdata;
            A_EMUX:  emux_d = wdata;
            A_ECG:   ecg_d  = wdata;
            A_RTOR1: rtor_d = wdata;
            default: ;
          endcase
        end
      end
    end else if (fall && rd_q && cnt_q >= 6'd9 && cnt_q <= 6'd31) begin
      // bit 23 went out at the 8th rising edge; later falls shift the rest
      miso_d  = rd_sh_q[22];
      rd_sh_d = {rd_sh_q[22:0], 1'b0};
    end
  end

  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  always_comb begin
    push_ok  = sample_valid & ~flush & (~full | pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      level_d = level_q + LW'(push_ok) - LW'(pop);
      if (sample_valid && full && !pop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_s3_q <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      cs_s1_q   <= 1'b0;
      cs_s2_q   <= 1'b0;
      armed_q   <= 1'b0;
      cnt_q     <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      pop_ok_q  <= 1'b0;
      rd_sh_q   <= '0;
      miso_q    <= 1'b0;
      gen_q     <= GEN_DEF;
      cal_q     <= CAL_DEF;
      emux_q    <= EMUX_DEF;
      ecg_q     <= ECG_DEF;
      rtor_q    <= RTOR1_DEF;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      sw_q      <= 1'b0;
      sy_q      <= 1'b0;
    end else begin
      sclk_s1_q <= sclk;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      mosi_s1_q <= mosi;
      mosi_s2_q <= mosi_s1_q;
      cs_s1_q   <= cs;
      cs_s2_q   <= cs_s1_q;
      armed_q   <= armed_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      pop_ok_q  <= pop_ok_d;
      rd_sh_q   <= rd_sh_d;
      miso_q    <= miso_d;
      gen_q     <= gen_d;
      cal_q     <= cal_d;
      emux_q    <= emux_d;
      ecg_q     <= ecg_d;
      rtor_q    <= rtor_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      sw_q      <= sw_d;
      sy_q      <= sy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= sample_data;
  end

  assign miso          = miso_q;
  assign cnfg_gen      = gen_q;
  assign cnfg_ecg      = ecg_q;
  assign fifo_level    = level_q;
  assign fifo_overflow = ovf_q;
  assign sw_rst_pulse  = sw_q;
  assign synch_pulse   = sy_q;

endmodule
